// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU-to-slave bus bridge and the slaves behind it.
// The bridge and the slave models import this package, so the memory map is
// defined once.
//
// Contents:
//   - Region base/mask pairs for ROM, RAM and VGA.
//   - Default read data returned on an error completion.
//   - Bridge FSM state encoding.
//   - in_region(): base/mask match helper used by the address decoder.
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

    // ROM occupies 16 KiB at 0xB000_0000.
    localparam logic [31:0] ROM_BASE = 32'hB000_0000;
    localparam logic [31:0] ROM_MASK = 32'hFFFF_C000;

    // RAM occupies 64 KiB at 0x0000_0000.
    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK = 32'hFFFF_0000;

    // VGA register window is 256 bytes at 0xF000_0000.
    localparam logic [31:0] VGA_BASE = 32'hF000_0000;
    localparam logic [31:0] VGA_MASK = 32'hFFFF_FF00;

    // Data handed back to the CPU when an access fails.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Slave wait budget defaults; the wait counter is 4 bits wide.
    localparam int TIMEOUT_DEFAULT = 15;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } bridge_state_t;

    // An address belongs to a region when its masked bits equal the base.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/cpu_bus_bridge_addr_decoder.sv
// ---------------------------------------------------------------------------
// addr_decoder
// Purely combinational memory-map decoder for the CPU bus bridge.
//
// Ports:
//   addr      in  32  byte address from the CPU
//   rom       out  1  address falls in the ROM region
//   ram       out  1  address falls in the RAM region
//   vga       out  1  address falls in the VGA region
//   unmapped  out  1  address matches no region
// ---------------------------------------------------------------------------
module addr_decoder
    import cpu_bus_pkg::*;
(
    input  logic [31:0] addr,
    output logic        rom,
    output logic        ram,
    output logic        vga,
    output logic        unmapped
);

    // The regions do not overlap, so at most one select is high.
    always_comb begin
        rom      = in_region(addr, ROM_BASE, ROM_MASK);
        ram      = in_region(addr, RAM_BASE, RAM_MASK);
        vga      = in_region(addr, VGA_BASE, VGA_MASK);
        unmapped = !(rom || ram || vga);
    end

endmodule

// File: rtl/cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// cpu_bus_bridge
// Bridges a simple request/ready CPU port onto a cyc/stb/ack slave bus with
// one-hot slave selects, a bounded slave wait and error completion for
// unmapped or misaligned addresses.
//
// Parameters:
//   TIMEOUT   last wait-counter value at which a missing ack still counts
//             (1-15); the bus cycle lasts at most TIMEOUT+1 clocks
//   ERR_DATA  read data presented with an error completion
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   cpu_req    in   1  access request, held until cpu_ready
//   cpu_we     in   1  1 = write, 0 = read
//   cpu_addr   in  32  word-aligned byte address
//   cpu_wdata  in  32  write data
//   cpu_rdata  out 32  read data, valid with cpu_ready
//   cpu_ready  out  1  one-cycle completion pulse
//   cpu_err    out  1  error flag, qualified by cpu_ready
//   bus_cyc    out  1  bus cycle active
//   bus_stb    out  1  strobe, same as bus_cyc
//   bus_we     out  1  registered write enable
//   bus_adr    out 32  registered address
//   bus_dat_o  out 32  registered write data
//   bus_dat_i  in  32  slave read data
//   bus_ack    in   1  slave acknowledge
//   sel_rom    out  1  ROM select, only while bus_cyc
//   sel_ram    out  1  RAM select, only while bus_cyc
//   sel_vga    out  1  VGA select, only while bus_cyc
// ---------------------------------------------------------------------------
module cpu_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack,
    output logic        sel_rom,
    output logic        sel_ram,
    output logic        sel_vga
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

    bridge_state_t         state;
    bridge_state_t         next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [31:0]           rdata_q;
    logic [2:0]            sel_q;

    logic dec_rom;
    logic dec_ram;
    logic dec_vga;
    logic dec_unmapped;
    logic start_bad;
    logic accept;

    addr_decoder u_decoder (
        .addr     (cpu_addr),
        .rom      (dec_rom),
        .ram      (dec_ram),
        .vga      (dec_vga),
        .unmapped (dec_unmapped)
    );

    // A request that cannot be placed on the bus completes as an error
    // straight from IDLE without ever raising bus_cyc.
    assign start_bad = dec_unmapped || (cpu_addr[1:0] != 2'b00);
    assign accept    = (state == ST_IDLE) && (next_state == ST_ACCESS);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs. Ack is tested before the
    // timeout so a slave answering on the last allowed cycle still wins.
    // DONE and ERROR always fall back to IDLE, so a request held across
    // the completion cycle cannot restart until the following cycle.
    always_comb begin
        next_state = state;
        bus_cyc    = 1'b0;
        cpu_ready  = 1'b0;
        cpu_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    next_state = start_bad ? ST_ERROR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus_cyc = 1'b1;
                if (bus_ack) begin
                    next_state = ST_DONE;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    next_state = ST_ERROR;
                end
            end
            ST_DONE: begin
                cpu_ready  = 1'b1;
                next_state = ST_IDLE;
            end
            ST_ERROR: begin
                cpu_ready  = 1'b1;
                cpu_err    = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Bus-side copies of the request are captured only at the accept edge,
    // so the CPU may change its outputs freely once the access is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_we    <= 1'b0;
            bus_adr   <= '0;
            bus_dat_o <= '0;
            sel_q     <= '0;
        end else if (accept) begin
            bus_we    <= cpu_we;
            bus_adr   <= cpu_addr;
            bus_dat_o <= cpu_wdata;
            sel_q     <= {dec_rom, dec_ram, dec_vga};
        end
    end

    // Wait counter is 0 in the first ACCESS cycle and only advances while
    // the access continues; any other cycle parks it at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && (next_state == ST_ACCESS)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Slave data is latched on the ack edge for reads and writes alike;
    // an ack outside ACCESS is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if ((state == ST_ACCESS) && bus_ack) begin
            rdata_q <= bus_dat_i;
        end
    end

    // Selects are gated by bus_cyc so they read zero outside a bus cycle.
    always_comb begin
        bus_stb   = bus_cyc;
        sel_rom   = sel_q[2] && bus_cyc;
        sel_ram   = sel_q[1] && bus_cyc;
        sel_vga   = sel_q[0] && bus_cyc;
        cpu_rdata = (state == ST_ERROR) ? ERR_DATA : rdata_q;
    end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_bridge
// Directed, self-checking bench for cpu_bus_bridge. Each access pushes its
// expected completion onto a scoreboard queue; the entry is popped when
// cpu_ready is seen and compared against what the bridge produced.
// ---------------------------------------------------------------------------
module tb_cpu_bus_bridge;

    localparam int          TIMEOUT  = 15;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack;
    logic        sel_rom;
    logic        sel_ram;
    logic        sel_vga;

    int checks = 0;
    int failures = 0;
    int ready_pulses = 0;
    int expected_pulses = 0;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rdata;
        int          lat;
        int          cyc;
        logic        mapped;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat_o;
        logic [2:0]  sel;
    } exp_t;

    exp_t sb[$];

    cpu_bus_bridge #(
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .bus_cyc   (bus_cyc),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_adr   (bus_adr),
        .bus_dat_o (bus_dat_o),
        .bus_dat_i (bus_dat_i),
        .bus_ack   (bus_ack),
        .sel_rom   (sel_rom),
        .sel_ram   (sel_ram),
        .sel_vga   (sel_vga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every completion pulse so spurious pulses (e.g. after an
    // aborted access) show up against the number of accesses issued.
    always @(posedge clk) begin
        if (cpu_ready === 1'b1) ready_pulses <= ready_pulses + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    // Reference memory map written as plain inclusive ranges.
    function automatic logic [2:0] modelSel(input logic [31:0] a);
        if (a >= 32'hB000_0000 && a <= 32'hB000_3FFF) return 3'b100;
        if (a <= 32'h0000_FFFF) return 3'b010;
        if (a >= 32'hF000_0000 && a <= 32'hF000_00FF) return 3'b001;
        return 3'b000;
    endfunction

    // Issues one access; the slave acks in ACCESS cycle ack_delay+1
    // (ack_delay < 0 means the slave never answers).
    task automatic runAccess(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] dat_i,
                             input int ack_delay);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          cyc;
        bit          seen;
        logic        cap_we;
        logic [31:0] cap_adr;
        logic [31:0] cap_dat;
        logic [2:0]  cap_sel;
        int          waits;

        e.tag    = tag;
        e.sel    = modelSel(addr);
        e.mapped = (e.sel != 3'b000) && (addr[1:0] == 2'b00);
        e.we     = we;
        e.adr    = addr;
        e.dat_o  = wdata;
        if (!e.mapped) begin
            e.err = 1'b1;
            e.lat = 1;
            e.cyc = 0;
        end else begin
            waits = (ack_delay < 0 || ack_delay > TIMEOUT) ? TIMEOUT : ack_delay;
            e.err = (ack_delay < 0 || ack_delay > TIMEOUT);
            e.lat = waits + 2;
            e.cyc = waits + 1;
        end
        e.rdata     = e.err ? ERR_DATA : dat_i;
        e.chk_rdata = e.err || !we;
        sb.push_back(e);
        expected_pulses++;

        applyStimulus(1'b1, we, addr, wdata);
        bus_dat_i = dat_i;
        bus_ack   = 1'b0;
        lat = 0;
        cyc = 0;
        seen = 1'b0;
        cap_we = 1'b0;
        cap_adr = '0;
        cap_dat = '0;
        cap_sel = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus_cyc === 1'b1) begin
                cyc++;
                if (cyc == 1) begin
                    cap_we  = bus_we;
                    cap_adr = bus_adr;
                    cap_dat = bus_dat_o;
                    cap_sel = {sel_rom, sel_ram, sel_vga};
                    checkOutput({tag, "_stb"}, 32'(bus_stb), 32'd1);
                end
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
                cpu_we    = ~we;
                bus_ack   = (ack_delay >= 0) && (cyc - 1 == ack_delay);
            end
        end
        bus_ack = 1'b0;

        checkOutput({tag, "_ready_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            got = sb.pop_front();
            checkOutput({got.tag, "_err"}, 32'(cpu_err), 32'(got.err));
            if (got.chk_rdata) checkOutput({got.tag, "_rdata"}, cpu_rdata, got.rdata);
            checkOutput({got.tag, "_latency"}, 32'(lat), 32'(got.lat));
            checkOutput({got.tag, "_cyc_cycles"}, 32'(cyc), 32'(got.cyc));
            checkOutput({got.tag, "_cyc_at_ready"}, 32'(bus_cyc), 32'd0);
            checkOutput({got.tag, "_sel_at_ready"}, 32'({sel_rom, sel_ram, sel_vga}), 32'd0);
            if (got.mapped) begin
                checkOutput({got.tag, "_bus_we"}, 32'(cap_we), 32'(got.we));
                checkOutput({got.tag, "_bus_adr"}, cap_adr, got.adr);
                checkOutput({got.tag, "_bus_dat_o"}, cap_dat, got.dat_o);
                checkOutput({got.tag, "_sel"}, 32'(cap_sel), 32'(got.sel));
            end
        end

        // Request still high across the completion edge must not restart.
        @(negedge clk);
        checkOutput({tag, "_no_restart_cyc"}, 32'(bus_cyc), 32'd0);
        checkOutput({tag, "_single_ready"}, 32'(cpu_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        bus_ack   = 1'b0;
        bus_dat_i = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Outputs while held in reset.
        #3;
        checkOutput("rst_cyc", 32'(bus_cyc), 32'd0);
        checkOutput("rst_ready", 32'(cpu_ready), 32'd0);
        checkOutput("rst_err", 32'(cpu_err), 32'd0);
        checkOutput("rst_adr", bus_adr, 32'd0);
        checkOutput("rst_rdata", cpu_rdata, 32'd0);
        checkOutput("rst_sel", 32'({sel_rom, sel_ram, sel_vga}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // A stray ack in IDLE is ignored.
        bus_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("idle_ack_cyc", 32'(bus_cyc), 32'd0);
        checkOutput("idle_ack_ready", 32'(cpu_ready), 32'd0);
        bus_ack = 1'b0;

        runAccess("rom_rd", 1'b0, 32'hB000_0000, 32'h0, 32'h1234_5678, 0);
        runAccess("ram_wr", 1'b1, 32'h0000_0010, 32'hCAFE_BABE, 32'h0BAD_F00D, 3);
        runAccess("unmapped_rd", 1'b0, 32'h1000_0000, 32'h0, 32'h7777_7777, 0);
        runAccess("misaligned_rd", 1'b0, 32'hB000_0002, 32'h0, 32'h7777_7777, 0);
        runAccess("vga_timeout", 1'b0, 32'hF000_0040, 32'h0, 32'h1111_2222, -1);
        runAccess("vga_ack_at_timeout", 1'b0, 32'hF000_0080, 32'h0, 32'h3333_4444, TIMEOUT);

        // Reset asserted between clock edges in the middle of an access.
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h55AA_55AA);
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("midrst_pre_cyc", 32'(bus_cyc), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_cyc", 32'(bus_cyc), 32'd0);
        checkOutput("midrst_stb", 32'(bus_stb), 32'd0);
        checkOutput("midrst_ready", 32'(cpu_ready), 32'd0);
        checkOutput("midrst_err", 32'(cpu_err), 32'd0);
        checkOutput("midrst_sel_ram", 32'(sel_ram), 32'd0);
        checkOutput("midrst_adr", bus_adr, 32'd0);
        checkOutput("midrst_dat_o", bus_dat_o, 32'd0);
        checkOutput("midrst_rdata", cpu_rdata, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_after_cyc", 32'(bus_cyc), 32'd0);
        checkOutput("midrst_no_pulse", 32'(ready_pulses), 32'(expected_pulses));

        runAccess("post_reset_rd", 1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_5A5A, 1);

        @(negedge clk);
        checkOutput("total_pulses", 32'(ready_pulses), 32'(expected_pulses));
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
